enigma_driver: RTL and testbench
================================

// Module: enigma_driver
// PURPOSE
//  Initiator side of the enigma core interface (load/load_idx/code_in/encrypt/crypt_mode -> code_out/code_valid).
//  On start: streams the 192-entry rotor table (A 0-63, B 64-127, C 128-191) from a synchronous table ROM,
//  then feeds a ready/valid text stream as symbols and returns results on a buffered ready/valid stream.
//  Sits between the system message path and enigma_part2; replaces bench-driven loading in the system.
// PARAMETERS
//  IDLE=0, LOAD=1, GAP=2, CRYPT=3, DRAIN=4   FSM state encodings
//  CORE_LAT=1    cycles from encrypt/code_in sample to matching code_valid/code_out at the core
//  RES_DEPTH=4   result FIFO depth (power of 2, >= CORE_LAT+1)
//  GAP_CYC=2     cycles load=0, encrypt=0 between table load and first symbol
// PORTS
//  clk         in   1  clock
//  srst        in   1  reset; one clock; reset is synchronous and active-high
//  start       in   1  pulse; accepted only in IDLE
//  mode        in   1  0 encrypt / 1 decrypt; captured at start, driven on crypt_mode
//  tbl_rd      out  1  table ROM read enable
//  tbl_addr    out  8  table ROM address 0..191
//  tbl_data    in   6  ROM data, valid 1 cycle after tbl_rd
//  txt_valid   in   1  text symbol valid
//  txt_ready   out  1  text symbol accepted when valid&ready
//  txt_data    in   6  text symbol
//  txt_last    in   1  marks last symbol of message
//  load        out  1  core load strobe
//  load_idx    out  8  core table index
//  code_in     out  6  core symbol/table data
//  encrypt     out  1  core symbol strobe (core rotors step only when high)
//  crypt_mode  out  1  core mode
//  code_out    in   6  core result
//  code_valid  in   1  core result valid
//  res_valid   out  1  result valid
//  res_ready   in   1  result accepted when valid&ready
//  res_data    out  6  result symbol
//  res_last    out  1  marks result of txt_last symbol
//  busy        out  1  high in any state except IDLE
//  done        out  1  one-cycle pulse when DRAIN completes
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; FIFO empty; counters 0; srst mid-operation aborts, drops buffered results.
//  IDLE: start -> LOAD, capture mode. start while busy ignored.
//  LOAD: tbl_rd=1, tbl_addr 0..191 one per cycle; next cycle load=1, load_idx=addr_d1, code_in=tbl_data.
//   After index 191 is presented (193 cycles after start) -> GAP. load never high outside this window.
//  GAP: GAP_CYC cycles load=0, encrypt=0 -> CRYPT.
//  CRYPT: txt_ready = (fifo_count + in_flight) < RES_DEPTH. On handshake: next cycle encrypt=1, code_in=txt_data;
//   otherwise encrypt=0 (bubble; code_in holds). Handshake with txt_last -> DRAIN.
//  in_flight tracks issued symbols not yet returned (up to CORE_LAT); code_valid pushes code_out into FIFO,
//   last flag travels with a shift register of length CORE_LAT. FIFO never overflows by construction;
//   overflow is an assertion failure.
//  DRAIN: txt_ready=0; wait in_flight==0 and FIFO empty -> done pulse, IDLE.
//  Simultaneous FIFO push and pop: count unchanged. res_valid = FIFO non-empty; first-word not fall-through:
//   result visible 1 cycle after code_valid.
//  Address/index wrap: none; counters stop at 191. Message of 1 symbol (txt_last on first) is legal.
// CONFIGURATION
//  ENIGMA_DRV_SKIP_LOAD_EN: adds input skip_load (1b). start with skip_load=1 goes IDLE -> GAP directly,
//   tables retained in core from previous load. Without macro: every start performs full LOAD.
// STRUCTURE
//  enigma_pkg: state encodings, SYM_W=6, IDX_W=8, TBL_ENTRIES=192, ROTOR_ENTRIES=64.
//  Sub-module enigma_res_fifo (RES_DEPTH x 7b: data+last, count output); FSM, load counters, credit in top.
// TESTING
//  Reset then start, mode=0: load high exactly 192 cycles, load_idx 0..191, code_in matches ROM word per index.
//  24-symbol plaintext1, res_ready=1: res_data == ciphertext1[0..23], res_last on #23, done 1 pulse.
//  mode=1, ciphertext1 in -> plaintext1 out; crypt_mode=1 throughout CRYPT.
//  res_ready=0 for 10 cycles mid-message: txt_ready drops after 4 outstanding, no loss, order preserved.
//  txt_valid gaps every other cycle: encrypt pulses only on accepted symbols, results still golden.
//  srst asserted during CRYPT: next cycle all outputs 0, IDLE; fresh start gives golden output.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and sizing for the enigma core driver.
package enigma_pkg;

  localparam int unsigned SYM_W         = 6;
  localparam int unsigned IDX_W         = 8;
  localparam int unsigned TBL_ENTRIES   = 192;
  localparam int unsigned ROTOR_ENTRIES = 64;
  localparam int unsigned CORE_LAT      = 1;
  localparam int unsigned RES_DEPTH     = 4;
  localparam int unsigned GAP_CYC       = 2;
  localparam int unsigned CNT_W         = $clog2(RES_DEPTH) + 1;
  localparam int unsigned SUM_W         = CNT_W + 1;
  localparam int unsigned GAP_W         = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    CRYPT = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Result word carried through the result buffer.
  typedef struct packed {
    logic             last;
    logic [SYM_W-1:0] sym;
  } res_t;

endpackage

// File: rtl/enigma_driver_if.sv
// Text-in / result-out ready/valid streams of the enigma driver.
interface enigma_driver_if;
  import enigma_pkg::*;

  logic             txt_valid;
  logic             txt_ready;
  logic [SYM_W-1:0] txt_data;
  logic             txt_last;
  logic             res_valid;
  logic             res_ready;
  logic [SYM_W-1:0] res_data;
  logic             res_last;

  modport slave (
    input  txt_valid, txt_data, txt_last, res_ready,
    output txt_ready, res_valid, res_data, res_last
  );

  modport master (
    output txt_valid, txt_data, txt_last, res_ready,
    input  txt_ready, res_valid, res_data, res_last
  );

endinterface

// File: rtl/enigma_res_fifo.sv
// Small result FIFO (symbol + last flag) with occupancy count; reads as zero when empty.
module enigma_res_fifo
  import enigma_pkg::*;
#(
  parameter  int unsigned DEPTH = RES_DEPTH,
  localparam int unsigned CW    = $clog2(DEPTH) + 1,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  res_t          push_data,
  input  logic          pop,
  output res_t          pop_data,
  output logic [CW-1:0] count
);

  res_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credit flow control upstream must keep a push away from a full buffer.
  always_ff @(posedge clk) begin
    if (!srst && push && !do_pop) assert (count < CW'(DEPTH));
  end

endmodule

// File: rtl/enigma_driver.sv
// Initiator for the enigma core: loads the rotor table from ROM, then streams text through the core.
// Optional ENIGMA_DRV_SKIP_LOAD_EN adds skip_load to start straight into GAP with tables kept in the core.
module enigma_driver
  import enigma_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic             mode,
`ifdef ENIGMA_DRV_SKIP_LOAD_EN
  input  logic             skip_load,
`endif
  output logic             tbl_rd,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [SYM_W-1:0] tbl_data,
  enigma_driver_if.slave   strm,
  output logic             load,
  output logic [IDX_W-1:0] load_idx,
  output logic [SYM_W-1:0] code_in,
  output logic             encrypt,
  output logic             crypt_mode,
  input  logic [SYM_W-1:0] code_out,
  input  logic             code_valid,
  output logic             busy,
  output logic             done
);

  state_t              state;
  logic [SYM_W-1:0]    sym_q;
  logic                last_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic [CNT_W-1:0]    in_flight;
  logic [CNT_W-1:0]    fifo_count;
  logic [CORE_LAT-1:0] last_pipe;
  logic [SUM_W-1:0]    credit_used;
  logic                txt_hs;
  logic                res_push;
  logic                res_pop;
  logic                skip;
  res_t                push_word;
  res_t                pop_word;

`ifdef ENIGMA_DRV_SKIP_LOAD_EN
  assign skip = skip_load;
`else
  assign skip = 1'b0;
`endif

  // Credit covers both buffered results and symbols still inside the core.
  assign credit_used    = SUM_W'(fifo_count) + SUM_W'(in_flight);
  assign strm.txt_ready = (state == CRYPT) && (credit_used < SUM_W'(RES_DEPTH));
  assign txt_hs         = strm.txt_valid && strm.txt_ready;
  assign res_push       = code_valid && ((state == CRYPT) || (state == DRAIN));
  assign res_pop        = strm.res_valid && strm.res_ready;
  assign push_word      = '{last: last_pipe[CORE_LAT-1], sym: code_out};
  assign strm.res_valid = (fifo_count != '0);
  assign strm.res_data  = pop_word.sym;
  assign strm.res_last  = pop_word.last;
  // ROM data lands one cycle after its address, in step with the registered load strobe.
  assign code_in        = load ? tbl_data : sym_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      tbl_rd     <= 1'b0;
      tbl_addr   <= '0;
      load       <= 1'b0;
      load_idx   <= '0;
      sym_q      <= '0;
      last_q     <= 1'b0;
      encrypt    <= 1'b0;
      crypt_mode <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      done    <= 1'b0;
      encrypt <= 1'b0;
      load    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            crypt_mode <= mode;
            busy       <= 1'b1;
            tbl_addr   <= '0;
            gap_cnt    <= '0;
            if (skip) begin
              state <= GAP;
            end else begin
              state  <= LOAD;
              tbl_rd <= 1'b1;
            end
          end
        end
        LOAD: begin
          load     <= tbl_rd;
          load_idx <= tbl_addr;
          if (tbl_rd) begin
            if (tbl_addr == IDX_W'(TBL_ENTRIES - 1)) tbl_rd <= 1'b0;
            else                                     tbl_addr <= tbl_addr + 1'b1;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= CRYPT;
          else                                gap_cnt <= gap_cnt + 1'b1;
        end
        CRYPT: begin
          if (txt_hs) begin
            encrypt <= 1'b1;
            sym_q   <= strm.txt_data;
            last_q  <= strm.txt_last;
            if (strm.txt_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((in_flight == '0) && (fifo_count == '0)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding-symbol credit and the last-flag delay line matching core latency.
  always_ff @(posedge clk) begin
    if (srst) begin
      in_flight <= '0;
      last_pipe <= '0;
    end else begin
      case ({txt_hs, res_push})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   if (in_flight != '0) in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
      last_pipe[0] <= encrypt && last_q;
      for (int i = 1; i < CORE_LAT; i++) last_pipe[i] <= last_pipe[i-1];
    end
  end

  enigma_res_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (clk),
    .srst      (srst),
    .push      (res_push),
    .push_data (push_word),
    .pop       (res_pop),
    .pop_data  (pop_word),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_enigma_driver.sv
// Bench for enigma_driver: ROM and core emulation around the DUT, message-level reference model.
module tb_enigma_driver;
  import enigma_pkg::*;

  logic             clk = 1'b0;
  logic             srst, start, mode, skip_load;
  logic             tbl_rd;
  logic [IDX_W-1:0] tbl_addr;
  logic [SYM_W-1:0] tbl_data = '0;
  logic             load, encrypt, crypt_mode, busy, done;
  logic [IDX_W-1:0] load_idx;
  logic [SYM_W-1:0] code_in;
  logic [SYM_W-1:0] code_out = '0;
  logic             code_valid = 1'b0;

  enigma_driver_if strm();

  always #5 clk = ~clk;

  enigma_driver dut (
    .clk        (clk),
    .srst       (srst),
    .start      (start),
    .mode       (mode),
`ifdef ENIGMA_DRV_SKIP_LOAD_EN
    .skip_load  (skip_load),
`endif
    .tbl_rd     (tbl_rd),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .strm       (strm),
    .load       (load),
    .load_idx   (load_idx),
    .code_in    (code_in),
    .encrypt    (encrypt),
    .crypt_mode (crypt_mode),
    .code_out   (code_out),
    .code_valid (code_valid),
    .busy       (busy),
    .done       (done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Table ROM with one cycle read latency.
  logic [SYM_W-1:0] rom [TBL_ENTRIES];
  always @(posedge clk) if (tbl_rd) tbl_data <= rom[tbl_addr];

  // Core emulation: three stepping additive rotors built from whatever the driver loaded.
  logic [SYM_W-1:0] core_tbl [TBL_ENTRIES];
  logic [5:0] pa = '0, pb = '0, pc = '0;
  logic [5:0] key;
  always @(posedge clk) begin
    if (srst) begin
      code_valid <= 1'b0;
      code_out   <= '0;
    end else begin
      code_valid <= encrypt;
      if (load) begin
        core_tbl[load_idx] <= code_in;
        pa <= '0; pb <= '0; pc <= '0;
      end
      if (encrypt) begin
        key = core_tbl[pa] + core_tbl[64 + 32'(pb)] + core_tbl[128 + 32'(pc)];
        code_out <= crypt_mode ? code_in - key : code_in + key;
        pa <= pa + 6'd1;
        if (pa == 6'd63) pb <= pb + 6'd1;
        if (pa == 6'd63 && pb == 6'd63) pc <= pc + 6'd1;
      end
    end
  end

  // Reference: symbol k uses rotor offsets derived from k directly.
  function automatic logic [5:0] ref_sym(input int k, input logic [5:0] x, input logic m);
    int kv;
    kv = int'(rom[k % 64]) + int'(rom[64 + (k / 64) % 64]) + int'(rom[128 + (k / 4096) % 64]);
    if (m) return 6'((((int'(x) - kv) % 64) + 64) % 64);
    return 6'((int'(x) + kv) % 64);
  endfunction

  int   load_cnt = 0, load_base = 0, load_bad = 0, enc_cnt = 0, done_cnt = 0, mode_bad = 0;
  int   hs_cnt = 0, pop_cnt = 0;
  logic exp_mode = 1'b0;

  always @(negedge clk) begin
    if (load) begin
      if (32'(load_idx) !== 32'(load_cnt - load_base) || code_in !== rom[load_idx]) load_bad++;
      load_cnt++;
    end
    if (encrypt) enc_cnt++;
    if ((encrypt || strm.txt_ready) && crypt_mode !== exp_mode) mode_bad++;
    if (done) done_cnt++;
  end

  always @(posedge clk) begin
    if (strm.txt_valid && strm.txt_ready) hs_cnt++;
    if (strm.res_valid && strm.res_ready) pop_cnt++;
  end

  task automatic pulse_start(input logic m);
    @(negedge clk);
    load_base = load_cnt;
    exp_mode  = m;
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_msg(input string name, input logic m, input logic [5:0] msg [$],
                         input bit gaps, input bit stall, input bit restart);
    logic [5:0] exp_q [$];
    logic [5:0] got_d [$];
    logic       got_l [$];
    int n, enc0, done0, lbad0, mbad0, hs0, pop0, t;
    n = msg.size();
    for (int k = 0; k < n; k++) exp_q.push_back(ref_sym(k, msg[k], m));
    enc0 = enc_cnt; done0 = done_cnt; lbad0 = load_bad; mbad0 = mode_bad;
    hs0 = hs_cnt; pop0 = pop_cnt;
    pulse_start(m);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int w;
          @(negedge clk);
          if (gaps && (i % 2 == 1)) begin
            strm.txt_valid = 1'b0;
            @(negedge clk);
          end
          strm.txt_valid = 1'b1;
          strm.txt_data  = msg[i];
          strm.txt_last  = (i == n - 1);
          w = 0;
          while (!strm.txt_ready && w < 400) begin
            @(negedge clk);
            w++;
          end
          if (!strm.txt_ready) begin
            check({name, ".txt_timeout"}, 32'(strm.txt_ready), 32'd1);
            break;
          end
          @(posedge clk);
        end
        @(negedge clk);
        strm.txt_valid = 1'b0;
        strm.txt_last  = 1'b0;
      end
      begin
        int cyc, scyc;
        bit sdone;
        cyc = 0; scyc = 0; sdone = 0;
        strm.res_ready = 1'b1;
        while (got_d.size() < n && cyc < 2000) begin
          @(negedge clk);
          cyc++;
          if (stall && !sdone && got_d.size() >= 5) begin
            strm.res_ready = 1'b0;
            scyc++;
            if (scyc == 10) begin
              check({name, ".stall_txt_ready"}, 32'(strm.txt_ready), 32'd0);
              check({name, ".stall_outstanding"}, 32'((hs_cnt - hs0) - (pop_cnt - pop0)),
                    32'(RES_DEPTH));
              sdone = 1;
              strm.res_ready = 1'b1;
            end
          end
          if (strm.res_valid && strm.res_ready) begin
            got_d.push_back(strm.res_data);
            got_l.push_back(strm.res_last);
          end
        end
      end
      begin
        if (restart) begin
          repeat (50) @(negedge clk);
          start = 1'b1;
          mode  = ~m;
          @(negedge clk);
          start = 1'b0;
          mode  = m;
        end
      end
    join
    t = 0;
    while (done_cnt == done0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({name, ".load_cycles"}, 32'(load_cnt - load_base), 32'(TBL_ENTRIES));
    check({name, ".load_words_bad"}, 32'(load_bad - lbad0), 32'd0);
    check({name, ".encrypt_pulses"}, 32'(enc_cnt - enc0), 32'(n));
    check({name, ".done_pulses"}, 32'(done_cnt - done0), 32'd1);
    check({name, ".crypt_mode_bad"}, 32'(mode_bad - mbad0), 32'd0);
    check({name, ".busy_after"}, 32'(busy), 32'd0);
    check({name, ".res_count"}, 32'(got_d.size()), 32'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check($sformatf("%s.data[%0d]", name, i), 32'(got_d[i]), 32'(exp_q[i]));
      check($sformatf("%s.last[%0d]", name, i), 32'(got_l[i]), 32'(i == n - 1));
    end
  endtask

  logic [5:0] pt1 [$];
  logic [5:0] ct1 [$];
  logic [5:0] msg2 [$];
  logic [5:0] one [$];

  initial begin
    int w;
    srst = 1'b1; start = 1'b0; mode = 1'b0; skip_load = 1'b0;
    strm.txt_valid = 1'b0; strm.txt_data = '0; strm.txt_last = 1'b0; strm.res_ready = 1'b0;
    for (int i = 0; i < TBL_ENTRIES; i++) rom[i] = 6'($urandom_range(0, 63));
    for (int i = 0; i < 24; i++) pt1.push_back(6'($urandom_range(0, 63)));
    for (int i = 0; i < 24; i++) ct1.push_back(ref_sym(i, pt1[i], 1'b0));
    for (int i = 0; i < 24; i++) msg2.push_back(6'($urandom_range(0, 63)));
    one.push_back(6'($urandom_range(0, 63)));
    repeat (3) @(negedge clk);

    check("reset.busy", 32'(busy), 32'd0);
    check("reset.txt_ready", 32'(strm.txt_ready), 32'd0);
    check("reset.res_valid", 32'(strm.res_valid), 32'd0);
    check("reset.outputs", 32'({tbl_rd, tbl_addr, load, load_idx, code_in, encrypt, crypt_mode, done}), 32'd0);
    srst = 1'b0;

    run_msg("enc", 1'b0, pt1, 1'b0, 1'b0, 1'b1);
    run_msg("dec", 1'b1, ct1, 1'b0, 1'b0, 1'b0);
    run_msg("stall", 1'b0, pt1, 1'b0, 1'b1, 1'b0);
    run_msg("gaps", 1'b0, msg2, 1'b1, 1'b0, 1'b0);
    run_msg("single", 1'b1, one, 1'b0, 1'b0, 1'b0);

    // Abort mid-message with srst, then a fresh run must be golden again.
    pulse_start(1'b0);
    w = 0;
    while (!strm.txt_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("abort.reach_crypt", 32'(strm.txt_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      strm.txt_valid = 1'b1;
      strm.txt_data  = pt1[i];
      strm.txt_last  = 1'b0;
      @(negedge clk);
    end
    srst = 1'b1;
    strm.txt_valid = 1'b0;
    @(negedge clk);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.stream_outputs", 32'({strm.txt_ready, strm.res_valid, strm.res_data, strm.res_last}), 32'd0);
    check("abort.outputs", 32'({tbl_rd, tbl_addr, load, load_idx, code_in, encrypt, crypt_mode, done}), 32'd0);
    srst = 1'b0;
    @(negedge clk);
    run_msg("post_abort", 1'b0, pt1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
